ads_frame_readout: RTL and testbench

// - Downstream companion of the AFE sequencer. On every AFE_CLK rising edge it starts one conversion on the

---
 rtl/ads_frame_readout.sv | 208 ++++++++++++++++++++
 tb/tb_ads_frame_readout.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads_frame_readout.sv
// ads_frame_readout: per-channel serial ADC readout driven by the AFE channel clock.
// Each AFE_CLK rise starts settle -> conversion -> serial read -> one-cycle DONE,
// tagging the sample with a channel index that wraps every NUM_CH channels.
module ads_frame_readout #(
  parameter int SETTLE_CYC = 20,
  parameter int CONV_CYC   = 30,
  parameter int SCLK_HALF  = 2,
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 64
) (
  input  logic              CLK_100M,
  input  logic              CLK_RST,
  input  logic              ADS_INIT_OK,
  input  logic              AFE_CLK,
  input  logic              AFE_STI,
  output logic              ADS_CONVST,
  output logic              ADS_CS_N,
  output logic              ADS_SCLK,
  input  logic              ADS_SDO,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [5:0]        DATA_CH,
  output logic              DATA_VALID,
  output logic              FRAME_DONE,
  output logic              ERR_OVR
);

  localparam int CONVST_CYC = 4;
  localparam int CNT_MAX0   = (SETTLE_CYC > CONV_CYC) ? SETTLE_CYC : CONV_CYC;
  localparam int CNT_MAX    = (CNT_MAX0 > SCLK_HALF) ? CNT_MAX0 : SCLK_HALF;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int HALF_W     = $clog2(2 * DATA_W);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  CONV_LAST   = CNT_W'(CONV_CYC - 1);
  localparam logic [CNT_W-1:0]  CONVST_LAST = CNT_W'(CONVST_CYC - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST   = CNT_W'(SCLK_HALF - 1);
  localparam logic [HALF_W-1:0] HALFS_LAST  = HALF_W'(2 * DATA_W - 1);
  localparam logic [5:0]        CH_LAST     = 6'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CONV,
    S_READ,
    S_DONE
  } state_t;

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [HALF_W-1:0]   r_half, w_half_next;
  logic [DATA_W-1:0]   r_shift, w_shift_next;
  logic [5:0]          r_ch, w_ch_next;
  logic                r_afe_q;
  logic                r_convst, w_convst_next;
  logic                r_cs_n, w_cs_n_next;
  logic                r_sclk, w_sclk_next;
  logic [DATA_W-1:0]   r_dout, w_dout_next;
  logic [5:0]          r_dch, w_dch_next;
  logic                r_valid, w_valid_next;
  logic                r_fd, w_fd_next;
  logic                r_ovr, w_ovr_next;
  logic                w_rise;

  assign w_rise = AFE_CLK & ~r_afe_q;

  // AFE_CLK history keeps sampling during reset so a level that is already high
  // when reset releases is not mistaken for a fresh rise.
  always_ff @(posedge CLK_100M) begin
    r_afe_q <= AFE_CLK;
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK_100M) begin
    if (CLK_RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_half   <= '0;
      r_shift  <= '0;
      r_ch     <= '0;
      r_convst <= 1'b0;
      r_cs_n   <= 1'b1;
      r_sclk   <= 1'b0;
      r_dout   <= '0;
      r_dch    <= '0;
      r_valid  <= 1'b0;
      r_fd     <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_half   <= w_half_next;
      r_shift  <= w_shift_next;
      r_ch     <= w_ch_next;
      r_convst <= w_convst_next;
      r_cs_n   <= w_cs_n_next;
      r_sclk   <= w_sclk_next;
      r_dout   <= w_dout_next;
      r_dch    <= w_dch_next;
      r_valid  <= w_valid_next;
      r_fd     <= w_fd_next;
      r_ovr    <= w_ovr_next;
    end
  end

  // Next state plus next values of every output; outputs are computed one cycle
  // early so that they are registered yet line up with the state they belong to.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_half_next   = r_half;
    w_shift_next  = r_shift;
    w_ch_next     = r_ch;
    w_convst_next = 1'b0;
    w_cs_n_next   = 1'b1;
    w_sclk_next   = 1'b0;
    w_valid_next  = 1'b0;
    w_fd_next     = 1'b0;
    w_dout_next   = r_dout;
    w_dch_next    = r_dch;
    // A rise while busy is dropped but remembered; STI masks the rise entirely.
    w_ovr_next    = r_ovr | (w_rise & ~AFE_STI & (r_state != S_IDLE));

    unique case (r_state)
      S_IDLE: begin
        if (w_rise && ADS_INIT_OK) begin
          w_state_next = S_SETTLE;
          w_cnt_next   = '0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_next  = S_CONV;
          w_cnt_next    = '0;
          w_convst_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_CONV: begin
        if (r_cnt == CONV_LAST) begin
          w_state_next = S_READ;
          w_cnt_next   = '0;
          w_half_next  = '0;
          w_cs_n_next  = 1'b0;
        end else begin
          w_cnt_next    = r_cnt + CNT_W'(1);
          w_convst_next = (r_cnt < CONVST_LAST);
        end
      end
      S_READ: begin
        w_cs_n_next = 1'b0;
        w_sclk_next = r_sclk;
        if (r_cnt == HALF_LAST) begin
          w_cnt_next = '0;
          if (r_half == HALFS_LAST) begin
            // Last high half done: release the ADC and publish the word.
            w_state_next = S_DONE;
            w_cs_n_next  = 1'b1;
            w_sclk_next  = 1'b0;
            w_valid_next = 1'b1;
            w_dout_next  = r_shift;
            w_dch_next   = r_ch;
            w_fd_next    = (r_ch == CH_LAST);
            w_ch_next    = (r_ch == CH_LAST) ? 6'd0 : r_ch + 6'd1;
          end else begin
            w_half_next = r_half + HALF_W'(1);
            w_sclk_next = ~r_sclk;
            if (!r_sclk) begin
              w_shift_next = {r_shift[DATA_W-2:0], ADS_SDO};
            end
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Frame start wins over everything: abort, park the ADC pins, restart channels.
    if (AFE_STI) begin
      w_state_next  = S_IDLE;
      w_cnt_next    = '0;
      w_ch_next     = '0;
      w_convst_next = 1'b0;
      w_cs_n_next   = 1'b1;
      w_sclk_next   = 1'b0;
      w_valid_next  = 1'b0;
      w_fd_next     = 1'b0;
      w_dout_next   = r_dout;
      w_dch_next    = r_dch;
    end
  end

  assign ADS_CONVST = r_convst;
  assign ADS_CS_N   = r_cs_n;
  assign ADS_SCLK   = r_sclk;
  assign DATA_OUT   = r_dout;
  assign DATA_CH    = r_dch;
  assign DATA_VALID = r_valid;
  assign FRAME_DONE = r_fd;
  assign ERR_OVR    = r_ovr;

endmodule

// File: tb/tb_ads_frame_readout.sv
// Testbench for ads_frame_readout: an ADC model serves random words, a monitor
// records every VALID, and each test compares against channel/latency rules.
module tb_ads_frame_readout;

  localparam int LAT    = 20 + 30 + 2 * 2 * 16 + 1;
  localparam int NUM_CH = 64;

  logic        clk = 1'b0;
  logic        rst, init_ok, afe_clk, sti, sdo;
  logic        convst, cs_n, sclk, valid, fd, ovr;
  logic [15:0] dout;
  logic [5:0]  dch;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          t;
    logic [15:0] d;
    logic [5:0]  ch;
    logic        fd;
  } vrec_t;

  vrec_t vq[$];
  int    convst_cnt, convst_first, convst_last, csn_low_cnt, sclk_rises;
  logic  mon_prev_sclk;
  logic [15:0] adc_word;
  int    exp_ch;

  ads_frame_readout dut (
    .CLK_100M   (clk),
    .CLK_RST    (rst),
    .ADS_INIT_OK(init_ok),
    .AFE_CLK    (afe_clk),
    .AFE_STI    (sti),
    .ADS_CONVST (convst),
    .ADS_CS_N   (cs_n),
    .ADS_SCLK   (sclk),
    .ADS_SDO    (sdo),
    .DATA_OUT   (dout),
    .DATA_CH    (dch),
    .DATA_VALID (valid),
    .FRAME_DONE (fd),
    .ERR_OVR    (ovr)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Monitor: sample outputs mid-cycle and log each VALID.
  initial begin
    mon_prev_sclk = 1'b0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        vq.push_back('{cyc, dout, dch, fd});
        $display("VALID cycle=%0d ch=%0d data=%h frame_done=%b", cyc, dch, dout, fd);
      end
      if (convst === 1'b1) begin
        if (convst_cnt == 0) convst_first = cyc;
        convst_last = cyc;
        convst_cnt++;
      end
      if (cs_n === 1'b0) csn_low_cnt++;
      if (sclk === 1'b1 && mon_prev_sclk !== 1'b1) sclk_rises++;
      mon_prev_sclk = sclk;
    end
  end

  // ADC model: MSB presented once selected, next bit after every SCLK fall.
  initial begin
    int   idx;
    logic prev;
    idx  = 0;
    prev = 1'b0;
    sdo  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cs_n !== 1'b0) idx = 0;
      else if (prev === 1'b1 && sclk === 1'b0) idx++;
      prev = sclk;
      sdo  = (idx < 16) ? adc_word[15 - idx] : 1'b0;
    end
  end

  task automatic clear_obs();
    vq.delete();
    convst_cnt  = 0;
    convst_first = 0;
    convst_last = 0;
    csn_low_cnt = 0;
    sclk_rises  = 0;
  endtask

  task automatic pulse_rise(input int high_cyc, output int c0);
    @(posedge clk);
    #1;
    afe_clk = 1'b1;
    c0 = cyc;
    repeat (high_cyc) @(posedge clk);
    #1;
    afe_clk = 1'b0;
  endtask

  task automatic run_channel(input logic [15:0] w, output int c0);
    adc_word = w;
    pulse_rise(65, c0);
    repeat (65) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ch = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_ok = 1'b0; afe_clk = 1'b0; sti = 1'b0; adc_word = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (convst !== 1'b0) begin n_fail++; $display("FAIL reset_convst: got %b expected 0", convst); end
    n_checks++; if (cs_n !== 1'b1)   begin n_fail++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    n_checks++; if (sclk !== 1'b0)   begin n_fail++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    n_checks++; if (dout !== 16'h0)  begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", dout); end
    n_checks++; if (dch !== 6'd0)    begin n_fail++; $display("FAIL reset_dch: got %0d expected 0", dch); end
    n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (fd !== 1'b0)     begin n_fail++; $display("FAIL reset_fd: got %b expected 0", fd); end
    n_checks++; if (ovr !== 1'b0)    begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    init_ok = 1'b1;
    exp_ch = 0;
  endtask

  task automatic test_basic();
    int c0;
    clear_obs();
    run_channel(16'hA5C3, c0);
    n_checks++; if (vq.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", vq.size()); end
    if (vq.size() > 0) begin
      n_checks++; if (vq[0].t - c0 != LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", vq[0].t - c0, LAT); end
      n_checks++; if (vq[0].d !== 16'hA5C3) begin n_fail++; $display("FAIL basic_data: got %h expected a5c3", vq[0].d); end
      n_checks++; if (vq[0].ch !== 6'(exp_ch)) begin n_fail++; $display("FAIL basic_ch: got %0d expected %0d", vq[0].ch, exp_ch); end
      n_checks++; if (vq[0].fd !== 1'b0) begin n_fail++; $display("FAIL basic_fd: got %b expected 0", vq[0].fd); end
    end
    n_checks++; if (convst_first - c0 != 21) begin n_fail++; $display("FAIL basic_convst_first: got %0d expected 21", convst_first - c0); end
    n_checks++; if (convst_last - c0 != 24)  begin n_fail++; $display("FAIL basic_convst_last: got %0d expected 24", convst_last - c0); end
    n_checks++; if (convst_cnt != 4)         begin n_fail++; $display("FAIL basic_convst_cnt: got %0d expected 4", convst_cnt); end
    n_checks++; if (sclk_rises != 16)        begin n_fail++; $display("FAIL basic_sclk_pulses: got %0d expected 16", sclk_rises); end
    n_checks++; if (csn_low_cnt != 64)       begin n_fail++; $display("FAIL basic_cs_low_cycles: got %0d expected 64", csn_low_cnt); end
    exp_ch = (exp_ch + 1) % NUM_CH;
  endtask

  task automatic test_random();
    int c0;
    logic [15:0] w;
    for (int i = 0; i < 6; i++) begin
      clear_obs();
      w = 16'($urandom);
      run_channel(w, c0);
      n_checks++; if (vq.size() != 1) begin n_fail++; $display("FAIL rand_count: got %0d expected 1", vq.size()); end
      if (vq.size() > 0) begin
        n_checks++; if (vq[0].d !== w) begin n_fail++; $display("FAIL rand_data: got %h expected %h", vq[0].d, w); end
        n_checks++; if (vq[0].ch !== 6'(exp_ch)) begin n_fail++; $display("FAIL rand_ch: got %0d expected %0d", vq[0].ch, exp_ch); end
        n_checks++; if (vq[0].t - c0 != LAT) begin n_fail++; $display("FAIL rand_latency: got %0d expected %0d", vq[0].t - c0, LAT); end
      end
      exp_ch = (exp_ch + 1) % NUM_CH;
    end
  endtask

  task automatic test_frame();
    int c0;
    logic [15:0] w;
    @(posedge clk); #1; sti = 1'b1;
    @(posedge clk); #1; sti = 1'b0;
    exp_ch = 0;
    for (int i = 0; i < NUM_CH + 1; i++) begin
      clear_obs();
      w = 16'($urandom);
      run_channel(w, c0);
      n_checks++; if (vq.size() != 1) begin n_fail++; $display("FAIL frame_count: got %0d expected 1 (ch %0d)", vq.size(), exp_ch); end
      if (vq.size() > 0) begin
        n_checks++; if (vq[0].ch !== 6'(exp_ch)) begin n_fail++; $display("FAIL frame_ch: got %0d expected %0d", vq[0].ch, exp_ch); end
        n_checks++; if (vq[0].d !== w) begin n_fail++; $display("FAIL frame_data: got %h expected %h", vq[0].d, w); end
        n_checks++; if (vq[0].fd !== (exp_ch == NUM_CH - 1)) begin n_fail++; $display("FAIL frame_done: got %b expected %b (ch %0d)", vq[0].fd, (exp_ch == NUM_CH - 1), exp_ch); end
      end
      exp_ch = (exp_ch + 1) % NUM_CH;
    end
  endtask

  task automatic test_overrun();
    int c0, c1;
    logic [15:0] w;
    do_reset();
    clear_obs();
    w = 16'($urandom);
    adc_word = w;
    pulse_rise(30, c0);
    repeat (29) @(posedge clk);
    pulse_rise(30, c1);
    repeat (150) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", ovr); end
    n_checks++; if (vq.size() != 1) begin n_fail++; $display("FAIL ovr_valid_count: got %0d expected 1", vq.size()); end
    if (vq.size() > 0) begin
      n_checks++; if (vq[0].t - c0 != LAT) begin n_fail++; $display("FAIL ovr_latency: got %0d expected %0d", vq[0].t - c0, LAT); end
      n_checks++; if (vq[0].d !== w) begin n_fail++; $display("FAIL ovr_data: got %h expected %h", vq[0].d, w); end
    end
    exp_ch = (exp_ch + 1) % NUM_CH;
    clear_obs();
    w = 16'($urandom);
    run_channel(w, c0);
    @(negedge clk);
    n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", ovr); end
    n_checks++; if (vq.size() != 1 || vq[0].ch !== 6'(exp_ch)) begin n_fail++; $display("FAIL ovr_next_ch: got count %0d expected 1 with ch %0d", vq.size(), exp_ch); end
    exp_ch = (exp_ch + 1) % NUM_CH;
    do_reset();
    @(negedge clk);
    n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", ovr); end
  endtask

  task automatic test_sti_abort();
    int c0;
    logic [15:0] w;
    do_reset();
    run_channel(16'($urandom), c0);
    exp_ch = (exp_ch + 1) % NUM_CH;
    clear_obs();
    adc_word = 16'($urandom);
    pulse_rise(65, c0);
    repeat (14) @(posedge clk);
    @(posedge clk); #1; sti = 1'b1;
    @(posedge clk); #1; sti = 1'b0;
    @(negedge clk);
    n_checks++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL sti_cs_n: got %b expected 1", cs_n); end
    n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL sti_sclk: got %b expected 0", sclk); end
    repeat (80) @(posedge clk);
    n_checks++; if (vq.size() != 0) begin n_fail++; $display("FAIL sti_no_valid: got %0d expected 0", vq.size()); end
    exp_ch = 0;
    clear_obs();
    w = 16'($urandom);
    run_channel(w, c0);
    n_checks++; if (vq.size() != 1 || vq[0].ch !== 6'(exp_ch) || vq[0].d !== w) begin n_fail++; $display("FAIL sti_next: got count %0d expected 1 ch %0d data %h", vq.size(), exp_ch, w); end
    exp_ch = (exp_ch + 1) % NUM_CH;
  endtask

  task automatic test_reset_mid();
    int c0;
    logic [15:0] w;
    run_channel(16'($urandom) | 16'h8001, c0);
    exp_ch = (exp_ch + 1) % NUM_CH;
    clear_obs();
    adc_word = 16'($urandom);
    pulse_rise(65, c0);
    repeat (14) @(posedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cs_n !== 1'b1 || sclk !== 1'b0 || convst !== 1'b0) begin n_fail++; $display("FAIL rstmid_pins: got cs_n %b sclk %b convst %b expected 1 0 0", cs_n, sclk, convst); end
    n_checks++; if (dout !== 16'h0 || dch !== 6'd0) begin n_fail++; $display("FAIL rstmid_data: got %h ch %0d expected 0000 ch 0", dout, dch); end
    n_checks++; if (valid !== 1'b0 || fd !== 1'b0 || ovr !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b%b%b expected 000", valid, fd, ovr); end
    repeat (80) @(posedge clk);
    n_checks++; if (vq.size() != 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d expected 0", vq.size()); end
    exp_ch = 0;
    clear_obs();
    w = 16'($urandom);
    run_channel(w, c0);
    n_checks++; if (vq.size() != 1 || vq[0].ch !== 6'(exp_ch)) begin n_fail++; $display("FAIL rstmid_next: got count %0d expected 1 with ch %0d", vq.size(), exp_ch); end
    exp_ch = (exp_ch + 1) % NUM_CH;
  endtask

  task automatic test_init_off();
    int c0;
    logic [15:0] w;
    init_ok = 1'b0;
    clear_obs();
    for (int i = 0; i < 5; i++) run_channel(16'($urandom), c0);
    n_checks++; if (convst_cnt != 0)  begin n_fail++; $display("FAIL init_convst: got %0d cycles expected 0", convst_cnt); end
    n_checks++; if (csn_low_cnt != 0) begin n_fail++; $display("FAIL init_cs_n: got %0d low cycles expected 0", csn_low_cnt); end
    n_checks++; if (vq.size() != 0)   begin n_fail++; $display("FAIL init_valid: got %0d expected 0", vq.size()); end
    // Enable dropping mid-conversion must not stop that conversion.
    init_ok = 1'b1;
    clear_obs();
    w = 16'($urandom);
    adc_word = w;
    pulse_rise(10, c0);
    init_ok = 1'b0;
    repeat (120) @(posedge clk);
    n_checks++; if (vq.size() != 1 || vq[0].d !== w || vq[0].ch !== 6'(exp_ch)) begin n_fail++; $display("FAIL init_inflight: got count %0d expected 1 data %h ch %0d", vq.size(), w, exp_ch); end
    exp_ch = (exp_ch + 1) % NUM_CH;
    init_ok = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_frame();
    test_overrun();
    test_sti_abort();
    test_reset_mid();
    test_init_off();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
